// File: rtl/conv_pkg.sv
// Shared types and defaults for the circular-convolution datapath (loader and core).
package conv_pkg;

  localparam int unsigned CONV_SIZE_N      = 4;
  localparam int unsigned CONV_SIZE_M      = 4;
  localparam int unsigned CONV_WIDTH       = 8;
  localparam int unsigned CONV_HOLD_CYCLES = 10;

  localparam int unsigned CONV_IDX_MAX = (CONV_SIZE_N > CONV_SIZE_M) ? CONV_SIZE_N : CONV_SIZE_M;
  localparam int unsigned IDX_W        = (CONV_IDX_MAX > 1) ? $clog2(CONV_IDX_MAX) : 1;

  typedef logic signed [CONV_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/conv_hold_timer.sv
// Loadable down-counter that times the start window; done pulses on the last counted cycle.
module conv_hold_timer
  import conv_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = CONV_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  logic [HW-1:0] cnt;

  // Load the window length, then count down once per enabled cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= HW'(HOLD_CYCLES);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - HW'(1);
    end
  end

  assign done = count && (cnt == HW'(1));

endmodule

// File: rtl/conv_operand_loader.sv
// Serial-to-array operand loader for circular_convolution: fills A then B from a
// valid/ready stream, holds start for a fixed window, and checks framing via s_last.
// Build option: define ZERO_PAD_EN to treat an early s_last as a short frame that
// is zero-padded and run, instead of a framing error.
module conv_operand_loader
  import conv_pkg::*;
#(
  parameter int unsigned SIZE_N      = CONV_SIZE_N,
  parameter int unsigned SIZE_M      = CONV_SIZE_M,
  parameter int unsigned WIDTH       = CONV_WIDTH,
  parameter int unsigned HOLD_CYCLES = CONV_HOLD_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH-1:0]             s_data,
  input  logic                         s_last,
  output logic [SIZE_N-1:0][WIDTH-1:0] A,
  output logic [SIZE_M-1:0][WIDTH-1:0] B,
  output logic                         start,
  output logic                         busy,
  output logic                         frame_err
);

  localparam int unsigned IDX_MAX = (SIZE_N > SIZE_M) ? SIZE_N : SIZE_M;
  localparam int unsigned IW      = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam logic [IW-1:0] LAST_A = IW'(SIZE_N - 1);
  localparam logic [IW-1:0] LAST_B = IW'(SIZE_M - 1);

  loader_state_e                state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [SIZE_N-1:0][WIDTH-1:0] a_d;
  logic [SIZE_M-1:0][WIDTH-1:0] b_d;
  logic                         err_d;
  logic                         beat;
  logic                         tmr_load;
  logic                         tmr_count;
  logic                         tmr_done;

  assign s_ready = reset && (state_q != RUN);
  assign beat    = s_valid && s_ready;

  conv_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .count(tmr_count),
    .done (tmr_done)
  );

  // Next-state, array write and framing decisions.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = A;
    b_d       = B;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (beat) begin
          a_d[idx_q] = s_data;
          if (s_last) begin
            idx_d = '0;
`ifdef ZERO_PAD_EN
            for (int i = 0; i < int'(SIZE_N); i++) begin
              if (i > int'(idx_q)) a_d[i] = '0;
            end
            b_d      = '0;
            state_d  = RUN;
            tmr_load = 1'b1;
`else
            err_d   = 1'b1;
            state_d = LOAD_A;
`endif
          end else if (idx_q == LAST_A) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LOAD_B: begin
        if (beat) begin
          b_d[idx_q] = s_data;
          if (idx_q == LAST_B) begin
            idx_d = '0;
            if (s_last) begin
              state_d  = RUN;
              tmr_load = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_last) begin
            idx_d = '0;
`ifdef ZERO_PAD_EN
            for (int i = 0; i < int'(SIZE_M); i++) begin
              if (i > int'(idx_q)) b_d[i] = '0;
            end
            state_d  = RUN;
            tmr_load = 1'b1;
`else
            err_d   = 1'b1;
            state_d = LOAD_A;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      RUN: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (beat && s_last) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  // State, operand arrays and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= LOAD_A;
      idx_q     <= '0;
      A         <= '0;
      B         <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      A         <= a_d;
      B         <= b_d;
      start     <= (state_d == RUN);
      busy      <= !((state_d == LOAD_A) && (idx_d == '0));
      frame_err <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_operand_loader.sv
// Randomized self-checking bench for conv_operand_loader against a frame-level model.
module tb_conv_operand_loader;

  localparam int N = 4;
  localparam int M = 4;
  localparam int W = 8;
  localparam int H = 10;

  logic                clk;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic [W-1:0]        s_data;
  logic                s_last;
  logic [N-1:0][W-1:0] A;
  logic [M-1:0][W-1:0] B;
  logic                start;
  logic                busy;
  logic                frame_err;

  conv_operand_loader dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .A        (A),
    .B        (B),
    .start    (start),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: position within the frame, remaining start window, drain flag.
  logic [W-1:0] ea [N];
  logic [W-1:0] eb [M];
  int  pos   = 0;
  int  hold  = 0;
  bit  drain = 1'b0;
  bit  m_err = 1'b0;
  int  cyc   = 0;

  always @(posedge clk) begin
    m_err = 1'b0;
    if (!reset) begin
      pos = 0; hold = 0; drain = 1'b0;
      for (int k = 0; k < N; k++) ea[k] = '0;
      for (int k = 0; k < M; k++) eb[k] = '0;
    end else if (hold != 0) begin
      hold--;
    end else if (s_valid) begin
      if (drain) begin
        if (s_last) drain = 1'b0;
      end else begin
        if (pos < N) ea[pos] = s_data; else eb[pos-N] = s_data;
        if (pos == N + M - 1) begin
          if (s_last) hold = H;
          else begin m_err = 1'b1; drain = 1'b1; end
          pos = 0;
        end else if (s_last) begin
`ifdef ZERO_PAD_EN
          for (int k = pos + 1; k < N + M; k++) begin
            if (k < N) ea[k] = '0; else eb[k-N] = '0;
          end
          hold = H;
`else
          m_err = 1'b1;
`endif
          pos = 0;
        end else begin
          pos++;
        end
      end
    end
    cyc++;
  end

  function automatic logic [N*W-1:0] pack_a();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = ea[i];
    return v;
  endfunction

  function automatic logic [M*W-1:0] pack_b();
    logic [M*W-1:0] v;
    for (int i = 0; i < M; i++) v[i*W +: W] = eb[i];
    return v;
  endfunction

  // Per-cycle output comparison plus start-window period tracking.
  bit mon_en     = 1'b0;
  bit chk_period = 1'b0;
  bit prev_start = 1'b0;
  int rises      = 0;
  int last_rise  = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("s_ready",   64'(s_ready),   64'(reset && (hold == 0)));
      chk("start",     64'(start),     64'(hold != 0));
      chk("busy",      64'(busy),      64'(!(pos == 0 && !drain && hold == 0)));
      chk("frame_err", 64'(frame_err), 64'(m_err));
      chk("A",         64'(A),         64'(pack_a()));
      chk("B",         64'(B),         64'(pack_b()));
      if (start && !prev_start) begin
        rises++;
        if (chk_period && last_rise >= 0) chk("period", 64'(cyc - last_rise), 64'(N + M + H));
        last_rise = cyc;
      end
      prev_start = start;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] fd [16];

  task automatic send(input logic [W-1:0] d, input logic l, input int gap);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 64'(s_ready), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = W'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Send nb beats from fd; s_last on beat lp (-1 for none).
  task automatic send_seq(input int nb, input int lp, input int gap);
    for (int i = 0; i < nb; i++) send(fd[i], (i == lp), gap);
  endtask

  task automatic rand_fd();
    for (int i = 0; i < 16; i++) fd[i] = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    // 1: all-ones frame at full rate
    for (int i = 0; i < 8; i++) fd[i] = 8'd1;
    send_seq(8, 7, 0);
    idle(12);
    chk("t1_A", 64'(A), 64'h0101_0101);
    chk("t1_B", 64'(B), 64'h0101_0101);

    // 2: signed samples with s_valid toggling
    fd[0] = 8'd1;  fd[1] = 8'd2;  fd[2] = 8'd3;  fd[3] = 8'd4;
    fd[4] = 8'hff; fd[5] = 8'hfe; fd[6] = 8'hfd; fd[7] = 8'hfc;
    send_seq(8, 7, 1);
    idle(12);
    chk("t2_A", 64'(A), 64'h0403_0201);
    chk("t2_B", 64'(B), 64'hfcfd_feff);

    // 3: early s_last on beat 5, then a full frame
    rand_fd();
    send_seq(6, 5, 0);
    idle(12);
    rand_fd();
    send_seq(8, 7, 0);
    idle(12);

    // 4: missing s_last, three junk beats, then a full frame
    rand_fd();
    send_seq(8, -1, 0);
    rand_fd();
    send_seq(3, 2, 0);
    rand_fd();
    send_seq(8, 7, 0);
    idle(12);

    // 5: one-cycle reset during the start window
    rand_fd();
    send_seq(8, 7, 0);
    idle(3);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk("t5_A", 64'(A), 64'h0);
    chk("t5_B", 64'(B), 64'h0);
    chk("t5_start", 64'(start), 64'h0);
    rand_fd();
    send_seq(8, 7, 0);
    idle(12);

    // 6: back-to-back frames at full rate
    rises = 0; last_rise = -1; chk_period = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_fd();
      send_seq(8, 7, 0);
    end
    idle(12);
    chk_period = 1'b0;
    chk("t6_windows", 64'(rises), 64'(3));

    // Random mix of good, short and unterminated frames
    for (int f = 0; f < 40; f++) begin
      int kind, g, k;
      kind = int'($urandom_range(0, 2));
      g    = int'($urandom_range(0, 2));
      rand_fd();
      case (kind)
        0: send_seq(8, 7, g);
        1: begin k = int'($urandom_range(1, 7)); send_seq(k, k - 1, g); end
        default: begin
          send_seq(8, -1, g);
          rand_fd();
          k = int'($urandom_range(1, 4));
          send_seq(k, k - 1, g);
        end
      endcase
    end
    idle(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
